universal_shift_register_core: RTL and testbench
================================================

UNIVERSAL_SHIFT_REGISTER_CORE -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register width in bits (legal range 2..64).
REQ-002 The block SHALL have clock port clk, input, 1 bit; all state changes occur on the rising edge.
REQ-003 The block SHALL have reset port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have P_in, input, WIDTH bits: the parallel load data.
REQ-005 The block SHALL have SLin, input, 1 bit: the serial input for shift-left, entering bit 0.
REQ-006 The block SHALL have SRin, input, 1 bit: the serial input for shift-right, entering bit WIDTH-1.
REQ-007 The block SHALL have mode, input, 2 bits: the operation select.
REQ-008 The block SHALL have P_out, output, WIDTH bits: the registered contents, driven directly from flops.

Function
REQ-009 With mode=00 (hold), P_out SHALL keep its value on every rising edge.
REQ-010 With mode=01 (shift right), P_out SHALL become {SRin, P_out[WIDTH-1:1]} on the rising edge.
REQ-011 With mode=10 (shift left), P_out SHALL become {P_out[WIDTH-2:0], SLin} on the rising edge.
REQ-012 With mode=11 (parallel load), P_out SHALL become P_in on the rising edge.
REQ-013 Every operation SHALL have a latency of one clock; the new P_out is visible after the edge on which mode and data were sampled.
REQ-014 mode, P_in, SLin and SRin SHALL be sampled only at the rising edge; changes between edges SHALL have no effect.
REQ-015 SLin SHALL be ignored in every mode except 10, and SRin SHALL be ignored in every mode except 01.
REQ-016 The shifted-out bit (bit 0 on shift right, bit WIDTH-1 on shift left) SHALL be discarded; there is no wrap-around.
REQ-017 If mode is X or Z at an edge, the register SHALL hold its value.

Reset
REQ-018 When rst_n is low, P_out SHALL go to all zeros immediately, without waiting for a clock edge.
REQ-019 While rst_n is low, P_out SHALL stay at zero regardless of mode and the data inputs.
REQ-020 Reset asserted during any operation SHALL abort that operation; the first edge with rst_n high SHALL perform the mode selected at that edge, starting from zero.

Configuration
REQ-021 When macro USR_SERIAL_OUT_EN is defined, the block SHALL add output SRout (1 bit, equal to P_out[0]) and output SLout (1 bit, equal to P_out[WIDTH-1]), both combinational from the register.
REQ-022 When USR_SERIAL_OUT_EN is not defined, SRout and SLout SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Assert rst_n=0 with P_in=1111 and mode=11 -> P_out=0000 asynchronously, with P_out still 0000 at the next clock edges.
REQ-024 Release reset, then apply P_in=1010 and mode=11 for one edge -> P_out=1010; then apply mode=00 for one edge -> P_out=1010.
REQ-025 From 1010, apply mode=01 with SRin=1 for one edge -> P_out=1101.
REQ-026 From 1101, apply mode=10 with SLin=0 for one edge -> P_out=1010; then apply SLin=1 for one edge -> P_out=0101; then apply mode=00 -> 0101 is held.
REQ-027 From 0101, apply mode=01 with SRin=0 for four edges -> P_out=0000, with no wrap-around; with USR_SERIAL_OUT_EN defined, SRout shall trace 1,0,1,0 before each shift.
REQ-028 Pulse rst_n low between edges during a mode=10 sequence -> P_out=0000 immediately, and the next edge with SLin=1 gives P_out=0001.

Source files
------------

// File: rtl/universal_shift_register_core.sv
// Universal shift register: hold / shift right / shift left / parallel load, async active-low reset.
// Define USR_SERIAL_OUT_EN to expose the end bits as serial outputs SRout / SLout.

module universal_shift_register_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       par,
  input  logic       hi,
  input  logic       lo,
  output logic       q
);
  logic d;

  // Any mode outside the three active encodings (including X/Z) holds.
  always_comb begin
    d = q;
    case (mode)
      2'b01:   d = hi;
      2'b10:   d = lo;
      2'b11:   d = par;
      default: d = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else        q <= d;
endmodule

module universal_shift_register_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] P_in,
  input  logic             SLin,
  input  logic             SRin,
  input  logic [1:0]       mode,
`ifdef USR_SERIAL_OUT_EN
  output logic             SRout,
  output logic             SLout,
`endif
  output logic [WIDTH-1:0] P_out
);
  // Per-bit neighbour sources; the shifted-out end bit simply has no consumer.
  logic [WIDTH-1:0] from_hi, from_lo;
  assign from_hi = {SRin, P_out[WIDTH-1:1]};
  assign from_lo = {P_out[WIDTH-2:0], SLin};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    universal_shift_register_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .par   (P_in[i]),
      .hi    (from_hi[i]),
      .lo    (from_lo[i]),
      .q     (P_out[i])
    );
  end

`ifdef USR_SERIAL_OUT_EN
  assign SRout = P_out[0];
  assign SLout = P_out[WIDTH-1];
`endif
endmodule

// File: tb/tb_universal_shift_register_core.sv
// Directed bench for universal_shift_register_core (WIDTH=4): vector table plus reset/timing corners.

module tb_universal_shift_register_core;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] P_in;
  logic         SLin, SRin;
  logic [1:0]   mode;
  logic [W-1:0] P_out;
`ifdef USR_SERIAL_OUT_EN
  logic         SRout, SLout;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  universal_shift_register_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .P_in  (P_in),
    .SLin  (SLin),
    .SRin  (SRin),
    .mode  (mode),
`ifdef USR_SERIAL_OUT_EN
    .SRout (SRout),
    .SLout (SLout),
`endif
    .P_out (P_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic [W-1:0] p_in;
    logic         slin;
    logic         srin;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"load_1010",  2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010};
    vecs[1]  = '{"hold",       2'b00, 4'b1111, 1'b1, 1'b1, 4'b1010};
    vecs[2]  = '{"shr_sr1",    2'b01, 4'b0000, 1'b1, 1'b1, 4'b1101};
    vecs[3]  = '{"shl_sl0",    2'b10, 4'b1111, 1'b0, 1'b1, 4'b1010};
    vecs[4]  = '{"shl_sl1",    2'b10, 4'b0000, 1'b1, 1'b0, 4'b0101};
    vecs[5]  = '{"hold_0101",  2'b00, 4'b0000, 1'b1, 1'b1, 4'b0101};
    vecs[6]  = '{"shr0_a",     2'b01, 4'b1111, 1'b1, 1'b0, 4'b0010};
    vecs[7]  = '{"shr0_b",     2'b01, 4'b1111, 1'b1, 1'b0, 4'b0001};
    vecs[8]  = '{"shr0_c",     2'b01, 4'b1111, 1'b1, 1'b0, 4'b0000};
    vecs[9]  = '{"shr0_d",     2'b01, 4'b1111, 1'b1, 1'b0, 4'b0000};
    vecs[10] = '{"load_0110",  2'b11, 4'b0110, 1'b0, 1'b0, 4'b0110};
    vecs[11] = '{"shl_a",      2'b10, 4'b0000, 1'b0, 1'b1, 4'b1100};
    vecs[12] = '{"shl_b",      2'b10, 4'b0000, 1'b0, 1'b1, 4'b1000};
    vecs[13] = '{"shl_c",      2'b10, 4'b0000, 1'b0, 1'b1, 4'b0000};
    vecs[14] = '{"shr_in1",    2'b01, 4'b0000, 1'b0, 1'b1, 4'b1000};
    vecs[15] = '{"load_1001",  2'b11, 4'b1001, 1'b0, 1'b0, 4'b1001};

    rst_n = 1'b1; mode = 2'b11; P_in = 4'b1111; SLin = 1'b0; SRin = 1'b0;

    // Preload non-zero contents so the asynchronous clear is observable.
    step();
    check("preload", P_out, 4'b1111);
    #2 rst_n = 1'b0;
    #1 check("async_reset", P_out, 4'b0000);
    step();
    check("reset_held_1", P_out, 4'b0000);
    step();
    check("reset_held_2", P_out, 4'b0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      mode = vecs[i].mode; P_in = vecs[i].p_in;
      SLin = vecs[i].slin; SRin = vecs[i].srin;
`ifdef USR_SERIAL_OUT_EN
      if (i >= 6 && i <= 9) begin
        total_cnt++;
        if (SRout === (i[0] ? 1'b0 : 1'b1)) pass_cnt++;
        else $display("FAIL srout_trace_%0d: got %b expected %b", i, SRout, ~i[0]);
      end
`endif
      step();
      check(vecs[i].name, P_out, vecs[i].exp);
`ifdef USR_SERIAL_OUT_EN
      check({vecs[i].name, "_ends"}, {2'b00, SLout, SRout},
            {2'b00, vecs[i].exp[W-1], vecs[i].exp[0]});
`endif
    end

    // Input changes between edges must not disturb the register.
    mode = 2'b00;
    #3 mode = 2'b11; P_in = 4'b0000;
    #3 check("mid_cycle_no_effect", P_out, 4'b1001);
    step();
    check("load_after_mid_change", P_out, 4'b0000);

    // Unknown mode holds.
    mode = 2'b11; P_in = 4'b0011;
    step();
    check("load_0011", P_out, 4'b0011);
    mode = 2'bxx; P_in = 4'b1111;
    step();
    check("mode_x_hold", P_out, 4'b0011);

    // Reset pulse between edges of a shift-left run, then resume from zero.
    mode = 2'b10; SLin = 1'b1;
    step();
    check("shl_before_pulse", P_out, 4'b0111);
    #2 rst_n = 1'b0;
    #1 check("pulse_reset_async", P_out, 4'b0000);
    #1 rst_n = 1'b1;
    step();
    check("shl_after_pulse", P_out, 4'b0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
